// File: rtl/fetch_queue.sv
// Instruction fetch queue: walks a PC through a combinational ROM and buffers
// {instr, pc, pc+4} entries for decode. Optional perf counters: FETCH_QUEUE_PERF_EN.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   _reset,
  output logic [XLEN-1:0]        imem_addr,
  output logic                   imem_req,
  input  logic [XLEN-1:0]        imem_rdata,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [XLEN-1:0]        deq_instr,
  output logic [XLEN-1:0]        deq_pc,
  output logic [XLEN-1:0]        deq_pc4,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            perf_full_cycles,
  output logic [31:0]            perf_redirects
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [XLEN-1:0] instrMem_q [DEPTH];
  logic [XLEN-1:0] pcMem_q    [DEPTH];
  logic [XLEN-1:0] pc4Mem_q   [DEPTH];
  logic            fullBlock, push, pop;
  logic            unusedPcBits;

  assign unusedPcBits = ^redirect_pc[1:0];

  // A full queue still accepts a fetch when the head leaves in the same cycle.
  always_comb begin
    deq_valid = (count_q != '0);
    fullBlock = (count_q == CNTW'(DEPTH)) && !(deq_valid && deq_ready);
    imem_req  = !fullBlock && !redirect;
    push      = imem_req;
    pop       = deq_valid && deq_ready && !redirect;

    fetchPc_d = fetchPc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (redirect) begin
      fetchPc_d = {redirect_pc[XLEN-1:2], 2'b00};
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end else begin
      if (push) begin
        fetchPc_d = fetchPc_q + XLEN'(4);
        tail_d    = tail_q + PTRW'(1);
      end
      if (pop) begin
        head_d = head_q + PTRW'(1);
      end
      count_d = count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      fetchPc_q <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instrMem_q[i] <= '0;
        pcMem_q[i]    <= '0;
        pc4Mem_q[i]   <= '0;
      end
    end else if (push) begin
      instrMem_q[tail_q] <= imem_rdata;
      pcMem_q[tail_q]    <= fetchPc_q;
      pc4Mem_q[tail_q]   <= fetchPc_q + XLEN'(4);
    end
  end

  assign imem_addr = fetchPc_q;
  assign deq_instr = instrMem_q[head_q];
  assign deq_pc    = pcMem_q[head_q];
  assign deq_pc4   = pc4Mem_q[head_q];
  assign count     = count_q;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perfFull_q, perfRedir_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      perfFull_q  <= '0;
      perfRedir_q <= '0;
    end else begin
      if (fullBlock && (perfFull_q != '1)) begin
        perfFull_q <= perfFull_q + 32'd1;
      end
      if (redirect && (perfRedir_q != '1)) begin
        perfRedir_q <= perfRedir_q + 32'd1;
      end
    end
  end

  assign perf_full_cycles = perfFull_q;
  assign perf_redirects   = perfRedir_q;
`else
  assign perf_full_cycles = '0;
  assign perf_redirects   = '0;
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001: Parameter XLEN, default 32, width of addresses and instruction words.
REQ-002: Parameter DEPTH, default 4, number of queue entries; power of two, >= 2.
REQ-003: Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: _reset  input  1  reset, synchronous and active-low.
REQ-006: imem_addr  output  XLEN  fetch address presented to instruction ROM (combinational read, same-cycle data).
REQ-007: imem_req  output  1  high when the current imem_addr is being fetched this cycle.
REQ-008: imem_rdata  input  XLEN  instruction word for imem_addr.
REQ-009: redirect  input  1  branch/jump taken; flush queue and restart fetch.
REQ-010: redirect_pc  input  XLEN  new fetch address when redirect=1.
REQ-011: deq_ready  input  1  decode stage accepts head entry (driven as ~stall).
REQ-012: deq_valid  output  1  head entry valid.
REQ-013: deq_instr / deq_pc / deq_pc4  output  XLEN each  head entry instruction, its PC, PC+4.
REQ-014: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015: perf_full_cycles / perf_redirects  output  32 each  performance counters (see Configuration).

Function
REQ-016: Internal fetch PC register drives imem_addr; imem_req = !full_block && !redirect, where full_block = (count==DEPTH) && !(deq_valid && deq_ready).
REQ-017: On a cycle with imem_req=1, the entry {imem_rdata, fetch PC, fetch PC+4} is written at the tail and fetch PC advances by 4 (mod 2^XLEN).
REQ-018: Dequeue occurs when deq_valid && deq_ready && !redirect; head pointer advances by one.
REQ-019: Enqueue-to-dequeue latency is one cycle: an entry written at edge N is visible on deq_* after edge N, never combinationally bypassed.
REQ-020: deq_valid = (count != 0); deq_* outputs are the head entry, don't-care values when deq_valid=0 but never X after reset.
REQ-021: Head and tail pointers wrap modulo DEPTH; count tracks pushes minus pops.
REQ-022: Full with simultaneous pop: push and pop both happen, count stays DEPTH.
REQ-023: Empty with push: count becomes 1; no pop that cycle since deq_valid=0.
REQ-024: Redirect has priority over push and pop: at the edge, count<=0, head<=tail<=0, fetch PC <= {redirect_pc[XLEN-1:2],2'b00}; no entry written.
REQ-025: Cycle after redirect: deq_valid=0, imem_addr=aligned redirect_pc, imem_req=1.
REQ-026: redirect_pc bits [1:0] are ignored (treated as zero).

Reset
REQ-027: On rising clk with _reset=0: fetch PC<=RESET_PC, head<=0, tail<=0, count<=0, all entry storage<=0, perf counters<=0.
REQ-028: Reset overrides redirect, push and pop in the same cycle; first cycle after release imem_addr=RESET_PC, imem_req=1, deq_valid=0.
REQ-029: Reset asserted mid-stream discards all queued entries; no partial entry survives.

Configuration
REQ-030: Macro FETCH_QUEUE_PERF_EN: when defined, perf_full_cycles increments each cycle full_block=1 and perf_redirects increments each accepted redirect, both saturating at 32'hFFFF_FFFF.
REQ-031: Without FETCH_QUEUE_PERF_EN, counter registers are not built and both perf outputs are constant 0; all other behaviour identical.

Verification
REQ-032: Reset release, deq_ready=1, ROM word k = k -> deq_valid from cycle 2, deq_pc 0,4,8,... with deq_instr 0,1,2,..., count steady at 1.
REQ-033: deq_ready=0 for 10 cycles after reset (DEPTH=4) -> count reaches 4 at cycle 4, imem_req=0 and imem_addr=16 thereafter, perf_full_cycles=6 with FETCH_QUEUE_PERF_EN.
REQ-034: Full queue, deq_ready=1 -> push and pop same cycle, count stays 4, deq_pc sequence 0,4,8,12,16 unbroken.
REQ-035: count=3, redirect=1 with redirect_pc=32'h0000_0103 -> next cycle count=0, deq_valid=0, imem_addr=32'h0000_0100; following cycle deq_pc=32'h100.
REQ-036: _reset=0 pulse for one cycle while count=4 -> next cycle count=0, imem_addr=RESET_PC, perf counters 0.
REQ-037: DEPTH=8, 20 pushes with random deq_ready -> deq_pc strictly increments by 4 across pointer wrap, no loss or duplication.
